// File: rtl/maze_blast_ctrl.sv
// Bomb explosion sequencer for the maze plan RAM: arbitrates two players, walks a
// cross of cells around the bomb and clears destructible bricks during video blanking.
module maze_blast_ctrl #(
    parameter int          RADIUS = 2,
    parameter int          MAZEX  = 25,
    parameter int          MAZEY  = 17,
    parameter logic [3:0]  BRICK  = 4'h2,
    parameter logic [3:0]  EMPTY  = 4'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        active,
    input  logic [1:0]  req,
    input  logic [4:0]  cellx0,
    input  logic [4:0]  cellx1,
    input  logic [4:0]  celly0,
    input  logic [4:0]  celly1,
    output logic [1:0]  ack,
    output logic        busy,
    output logic [2:0]  bricks,
    output logic [9:0]  ram_raddr,
    output logic [9:0]  ram_waddr,
    output logic [3:0]  ram_wdata,
    output logic        ram_we,
    input  logic [3:0]  ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_CENTER, S_READ, S_WAIT, S_EVAL, S_WRITE, S_NEXT, S_DONE
    } state_t;

    state_t      state_q, state_d;
    logic        rr_q, rr_d;
    logic        gnt_q, gnt_d;
    logic [4:0]  bx_q, bx_d, by_q, by_d;
    logic [4:0]  tx_q, tx_d, ty_q, ty_d;
    logic [1:0]  dir_q, dir_d;
    logic [2:0]  k_q, k_d;
    logic        ended_q, ended_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [2:0]  bricks_q, bricks_d;
    logic [1:0]  ack_q, ack_d;
    logic        busy_q, busy_d;
    logic [9:0]  raddr_q, raddr_d;
    logic [9:0]  waddr_q, waddr_d;
    logic [3:0]  wdata_q, wdata_d;
    logic        we_q, we_d;

    logic [5:0]  tx_s, ty_s;
    logic        oob_s;
    logic [1:0]  req_eff_s;
    logic        pick_s;

    // Target cell of the current scan step; bit 5 acts as the sign bit.
    always_comb begin
        tx_s = {1'b0, bx_q};
        ty_s = {1'b0, by_q};
        case (dir_q)
            2'd0:    ty_s = {1'b0, by_q} - {3'b000, k_q};
            2'd1:    ty_s = {1'b0, by_q} + {3'b000, k_q};
            2'd2:    tx_s = {1'b0, bx_q} - {3'b000, k_q};
            2'd3:    tx_s = {1'b0, bx_q} + {3'b000, k_q};
            default: tx_s = {1'b0, bx_q};
        endcase
        oob_s = tx_s[5] | ty_s[5] | (tx_s >= 6'(MAZEX)) | (ty_s >= 6'(MAZEY));
    end

    // Next-state and output decode for the explosion sequencer.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        gnt_d    = gnt_q;
        bx_d     = bx_q;
        by_d     = by_q;
        tx_d     = tx_q;
        ty_d     = ty_q;
        dir_d    = dir_q;
        k_d      = k_q;
        ended_d  = ended_q;
        cnt_d    = cnt_q;
        bricks_d = bricks_q;
        ack_d    = 2'b00;
        busy_d   = busy_q;
        raddr_d  = raddr_q;
        waddr_d  = waddr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        // The player just acked still shows req this cycle; do not re-grant it.
        req_eff_s = req & ~ack_q;
        pick_s    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_eff_s != 2'b00) begin
                    if (req_eff_s == 2'b11) begin
                        pick_s = rr_q;
                    end else begin
                        pick_s = req_eff_s[1];
                    end
                    gnt_d   = pick_s;
                    rr_d    = ~pick_s;
                    bx_d    = pick_s ? cellx1 : cellx0;
                    by_d    = pick_s ? celly1 : celly0;
                    cnt_d   = 3'd0;
                    busy_d  = 1'b1;
                    state_d = S_CENTER;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CENTER: begin
                if (!active) begin
                    we_d    = 1'b1;
                    waddr_d = {by_q, bx_q};
                    wdata_d = EMPTY;
                    dir_d   = 2'd0;
                    k_d     = 3'd1;
                    ended_d = 1'b0;
                    state_d = S_READ;
                end else begin
                    state_d = S_CENTER;
                end
            end
            S_READ: begin
                if (active) begin
                    state_d = S_READ;
                end else if (oob_s) begin
                    k_d     = 3'(RADIUS);
                    ended_d = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    tx_d    = tx_s[4:0];
                    ty_d    = ty_s[4:0];
                    raddr_d = {ty_s[4:0], tx_s[4:0]};
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Blanking lost during the RAM latency cycle: the read must be redone.
                if (active) begin
                    state_d = S_READ;
                end else begin
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                if (active) begin
                    state_d = S_EVAL;
                end else if (ram_rdata == EMPTY) begin
                    state_d = S_NEXT;
                end else if (ram_rdata == BRICK) begin
                    state_d = S_WRITE;
                end else begin
                    ended_d = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_WRITE: begin
                if (!active) begin
                    we_d    = 1'b1;
                    waddr_d = {ty_q, tx_q};
                    wdata_d = EMPTY;
                    cnt_d   = (cnt_q == 3'd7) ? cnt_q : cnt_q + 3'd1;
                    ended_d = 1'b1;
                    state_d = S_NEXT;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_NEXT: begin
                if ((k_q < 3'(RADIUS)) && !ended_q) begin
                    k_d     = k_q + 3'd1;
                    state_d = S_READ;
                end else if (dir_q != 2'd3) begin
                    dir_d   = dir_q + 2'd1;
                    k_d     = 3'd1;
                    ended_d = 1'b0;
                    state_d = S_READ;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                ack_d    = gnt_q ? 2'b10 : 2'b01;
                busy_d   = 1'b0;
                bricks_d = cnt_q;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any explosion at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            rr_q     <= 1'b0;
            gnt_q    <= 1'b0;
            bx_q     <= 5'd0;
            by_q     <= 5'd0;
            tx_q     <= 5'd0;
            ty_q     <= 5'd0;
            dir_q    <= 2'd0;
            k_q      <= 3'd0;
            ended_q  <= 1'b0;
            cnt_q    <= 3'd0;
            bricks_q <= 3'd0;
            ack_q    <= 2'b00;
            busy_q   <= 1'b0;
            raddr_q  <= 10'd0;
            waddr_q  <= 10'd0;
            wdata_q  <= 4'd0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            bx_q     <= bx_d;
            by_q     <= by_d;
            tx_q     <= tx_d;
            ty_q     <= ty_d;
            dir_q    <= dir_d;
            k_q      <= k_d;
            ended_q  <= ended_d;
            cnt_q    <= cnt_d;
            bricks_q <= bricks_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
            raddr_q  <= raddr_d;
            waddr_q  <= waddr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
        end
    end

    assign ack       = ack_q;
    assign busy      = busy_q;
    assign bricks    = bricks_q;
    assign ram_raddr = raddr_q;
    assign ram_waddr = waddr_q;
    assign ram_wdata = wdata_q;
    assign ram_we    = we_q;

endmodule
